uart_tx_ctrl: RTL

Transmit-side sequencer for the UART. Pops bytes from the TX FIFO and serializes each into one frame: start bit, 5–8 data bits LSB-first, optional parity, 1 or 2 stop bits. Bit timing comes from the oversampled `main_clk` tick enable. It sits between the TX FIFO and the `tx` pin and raises a one-cycle `frame_done` for the TX-empty interrupt logic.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_tx_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: transmit FSM states, parity modes and frame constants.
package uart_pkg;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP1,
      TX_STOP2
   } tx_state_t;

   typedef enum logic [1:0] {
      PAR_NONE,
      PAR_EVEN,
      PAR_ODD
   } parity_t;

   localparam int UART_DATA_BITS_BASE     = 5;
   localparam int UART_OVERSAMPLE_DEFAULT = 16;

   // 2'b11 is a second encoding of "no parity".
   function automatic parity_t decode_parity(input logic [1:0] cfg);
      parity_t mode;
      case (cfg)
         2'b01:   mode = PAR_EVEN;
         2'b10:   mode = PAR_ODD;
         default: mode = PAR_NONE;
      endcase
      return mode;
   endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops bytes from the TX FIFO and serializes each
// into start / 5-8 data bits LSB-first / optional parity / 1-2 stop bits.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       enable,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_dout,
   output logic       fifo_re,
   input  logic [1:0] cfg_data_bits,
   input  logic [1:0] cfg_parity,
   input  logic       cfg_double_stop,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

   localparam int TCW = $clog2(OVERSAMPLE);
   localparam logic [TCW-1:0] TICK_LAST = TCW'(OVERSAMPLE - 1);

   tx_state_t      state, state_next;
   logic [TCW-1:0] tick_cnt, tick_cnt_next;
   logic [2:0]     bit_cnt, bit_cnt_next;
   logic [7:0]     shreg, shreg_next;
   logic           par_acc, par_next;
   logic [2:0]     last_bit;
   parity_t        par_mode;
   logic           two_stop;
   logic           launch, bit_end, tx_next, done_next;

   assign launch  = (state == TX_IDLE) && tick && enable && !fifo_empty;
   assign bit_end = tick && (tick_cnt == TICK_LAST);
   assign fifo_re = launch;

   always_comb begin
      state_next    = state;
      tick_cnt_next = tick_cnt;
      bit_cnt_next  = bit_cnt;
      shreg_next    = shreg;
      par_next      = par_acc;
      done_next     = 1'b0;
      tx_next       = 1'b1;

      if (state == TX_IDLE) begin
         if (launch) begin
            state_next    = TX_START;
            tick_cnt_next = '0;
            bit_cnt_next  = '0;
            shreg_next    = fifo_dout;
            par_next      = 1'b0;
         end
      end else if (tick) begin
         if (!bit_end) begin
            tick_cnt_next = tick_cnt + 1'b1;
         end else begin
            tick_cnt_next = '0;
            case (state)
               TX_START: state_next = TX_DATA;
               TX_DATA: begin
                  // Fold the bit just sent into parity before it shifts out.
                  par_next   = par_acc ^ shreg[0];
                  shreg_next = {1'b0, shreg[7:1]};
                  if (bit_cnt == last_bit) begin
                     bit_cnt_next = '0;
                     state_next   = (par_mode == PAR_NONE) ? TX_STOP1 : TX_PARITY;
                  end else begin
                     bit_cnt_next = bit_cnt + 3'd1;
                  end
               end
               TX_PARITY: state_next = TX_STOP1;
               TX_STOP1: begin
                  state_next = two_stop ? TX_STOP2 : TX_IDLE;
                  done_next  = !two_stop;
               end
               TX_STOP2: begin
                  state_next = TX_IDLE;
                  done_next  = 1'b1;
               end
               default: state_next = TX_IDLE;
            endcase
         end
      end

      // Line level is derived from the upcoming state so tx comes straight off a flop.
      case (state_next)
         TX_START:  tx_next = 1'b0;
         TX_DATA:   tx_next = shreg_next[0];
         TX_PARITY: tx_next = (par_mode == PAR_ODD) ? ~par_next : par_next;
         default:   tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= TX_IDLE;
         tick_cnt   <= '0;
         bit_cnt    <= '0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         tick_cnt   <= tick_cnt_next;
         bit_cnt    <= bit_cnt_next;
         tx         <= tx_next;
         busy       <= (state_next != TX_IDLE);
         frame_done <= done_next;
      end
   end

   // Frame configuration is captured at launch and held for the whole frame.
   always_ff @(posedge clk) begin
      shreg   <= shreg_next;
      par_acc <= par_next;
      if (launch) begin
         last_bit <= {1'b0, cfg_data_bits} + 3'(UART_DATA_BITS_BASE - 1);
         par_mode <= decode_parity(cfg_parity);
         two_stop <= cfg_double_stop;
      end
   end

endmodule
